// File: rtl/mem_if_pkg.sv
// Shared definitions for the CPU memory handshake: FSM state encoding,
// READ_WRITE / WORD_BYTE encodings, default latency and a lane-mask helper.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic WB_WORD  = 1'b1;
  localparam logic WB_BYTE  = 1'b0;

  localparam int DEFAULT_LATENCY = 2;
  localparam int CNT_W           = 4;

  // Byte lanes touched by an access: all four for a word, one for a byte.
  function automatic logic [3:0] lane_mask(input logic word, input logic [1:0] offs);
    lane_mask = word ? 4'b1111 : (4'b0001 << offs);
  endfunction

endpackage

// File: rtl/mem_bank4x64x8.sv
// Byte-laned RAM: four independent 8-bit lane arrays sharing a word address.
// Each lane has its own write enable; the 32-bit word reads combinationally.
module mem_bank4x64x8 #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [3:0]        lane_we,
  input  logic [ADDR_W-3:0] word_addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      // Write this lane's byte when its enable is set.
      always_ff @(posedge clk) begin
        if (lane_we[gi]) begin
          lane_mem[word_addr] <= wdata[gi*8 +: 8];
        end
      end

      assign rdata[gi*8 +: 8] = lane_mem[word_addr];
    end
  endgenerate

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the MFA/MFC handshake. A request is latched in
// IDLE, waits LATENCY cycles, performs one ACCESS cycle (read strobe or write
// strobe) and then holds MFC until the CPU drops MFA.
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int ADDR_W  = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MFA,
  input  logic              READ_WRITE,
  input  logic              WORD_BYTE,
  input  logic [ADDR_W-1:0] MEMADD,
  input  logic [31:0]       MEMDAT_IN,
  output logic [31:0]       MEMDAT_OUT,
  output logic              MEMLOAD,
  output logic              MEMSTORE,
  output logic              MFC
);

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              rw_reg;
  logic              wb_reg;

  logic [3:0]        lane_we;
  logic [31:0]       wdata;
  logic [31:0]       rd_word;
  logic [31:0]       read_val;

  // The write lands on the edge that ends ACCESS; a reset on that edge
  // suppresses it so an aborted access never touches the RAM.
  assign lane_we = (state_reg == ACCESS && rw_reg == RW_WRITE && Reset)
                   ? lane_mask(wb_reg, addr_reg[1:0]) : 4'b0000;

  // Byte writes replicate the byte onto every lane; only the enabled lane stores it.
  assign wdata = (wb_reg == WB_WORD) ? MEMDAT_IN : {4{MEMDAT_IN[7:0]}};

  mem_bank4x64x8 #(
    .ADDR_W(ADDR_W)
  ) u_bank (
    .clk      (Clk),
    .lane_we  (lane_we),
    .word_addr(addr_reg[ADDR_W-1:2]),
    .wdata    (wdata),
    .rdata    (rd_word)
  );

  // Word reads ignore the low address bits; byte reads zero-extend the selected lane.
  always_comb begin
    read_val = rd_word;
    if (wb_reg == WB_BYTE) begin
      read_val = {24'h0, rd_word[{addr_reg[1:0], 3'b000} +: 8]};
    end
  end

  // Handshake FSM with registered strobes, MFC and read data.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      MFC        <= 1'b0;
      MEMLOAD    <= 1'b0;
      MEMSTORE   <= 1'b0;
      MEMDAT_OUT <= 32'h0;
    end else begin
      MEMLOAD  <= 1'b0;
      MEMSTORE <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (MFA) begin
            addr_reg  <= MEMADD;
            rw_reg    <= READ_WRITE;
            wb_reg    <= WORD_BYTE;
            cnt_reg   <= CNT_W'(LATENCY - 1);
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg == '0) begin
            state_reg <= ACCESS;
            if (rw_reg == RW_READ) begin
              MEMLOAD    <= 1'b1;
              MEMDAT_OUT <= read_val;
            end else begin
              MEMSTORE <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ACCESS: begin
          state_reg <= DONE;
          MFC       <= 1'b1;
        end
        DONE: begin
          if (!MFA) begin
            state_reg <= IDLE;
            MFC       <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a timeline/byte-array model checked every
// cycle, plus literal expectations for data values, strobe timing and MFC length.
module tb_mem_responder;

  localparam int LAT = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        MFA;
  logic        READ_WRITE;
  logic        WORD_BYTE;
  logic [7:0]  MEMADD;
  logic [31:0] MEMDAT_IN;
  logic [31:0] MEMDAT_OUT;
  logic        MEMLOAD;
  logic        MEMSTORE;
  logic        MFC;

  always #5 Clk = ~Clk;

  mem_responder #(
    .LATENCY(LAT),
    .ADDR_W (8)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .MFA       (MFA),
    .READ_WRITE(READ_WRITE),
    .WORD_BYTE (WORD_BYTE),
    .MEMADD    (MEMADD),
    .MEMDAT_IN (MEMDAT_IN),
    .MEMDAT_OUT(MEMDAT_OUT),
    .MEMLOAD   (MEMLOAD),
    .MEMSTORE  (MEMSTORE),
    .MFC       (MFC)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [256];
  bit          model_live = 1'b0;
  logic        exp_mfc    = 1'b0;
  logic        exp_load   = 1'b0;
  logic        exp_store  = 1'b0;
  logic [31:0] exp_dout   = 32'h0;

  function automatic logic [31:0] ref_read(input logic [7:0] a, input logic wb);
    int b;
    b = int'(a) & 32'hFC;
    if (wb) return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    return {24'h0, ref_mem[a]};
  endfunction

  task automatic ref_write(input logic [7:0] a, input logic wb, input logic [31:0] d);
    int b;
    b = int'(a) & 32'hFC;
    if (wb) begin
      for (int i = 0; i < 4; i++) ref_mem[b+i] = d[8*i +: 8];
    end else begin
      ref_mem[a] = d[7:0];
    end
  endtask

  // Model: a request accepted at edge t0 strobes LAT edges later, writes and
  // raises MFC at LAT+1, and releases on the first later edge with MFA low.
  initial begin
    int edge_no;
    int t0;
    int k;
    bit busy;
    logic [7:0] r_addr;
    logic r_rw;
    logic r_wb;
    edge_no = 0;
    t0 = 0;
    busy = 1'b0;
    r_addr = 8'h0;
    r_rw = 1'b0;
    r_wb = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h0;
    forever begin
      @(posedge Clk);
      edge_no++;
      if (!Reset) begin
        model_live = 1'b1;
        busy = 1'b0;
        exp_mfc = 1'b0;
        exp_load = 1'b0;
        exp_store = 1'b0;
        exp_dout = 32'h0;
      end else begin
        exp_load = 1'b0;
        exp_store = 1'b0;
        if (!busy) begin
          if (MFA) begin
            busy = 1'b1;
            t0 = edge_no;
            r_addr = MEMADD;
            r_rw = READ_WRITE;
            r_wb = WORD_BYTE;
          end
        end else begin
          k = edge_no - t0;
          if (k == LAT) begin
            if (r_rw) begin
              exp_load = 1'b1;
              exp_dout = ref_read(r_addr, r_wb);
            end else begin
              exp_store = 1'b1;
            end
          end else if (k == LAT + 1) begin
            if (!r_rw) ref_write(r_addr, r_wb, MEMDAT_IN);
            exp_mfc = 1'b1;
          end else if (k > LAT + 1 && !MFA) begin
            busy = 1'b0;
            exp_mfc = 1'b0;
          end
        end
      end
    end
  end

  // Per-cycle compare against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge Clk);
      if (model_live) begin
        check("cyc_MFC", MFC, exp_mfc);
        check("cyc_MEMLOAD", MEMLOAD, exp_load);
        check("cyc_MEMSTORE", MEMSTORE, exp_store);
        check("cyc_MEMDAT_OUT", MEMDAT_OUT, exp_dout);
      end
    end
  end

  // One handshake; checks strobe cycle, MFC start cycle, MFC length and read data.
  task automatic request(input string tag, input logic rw, input logic wb,
                         input logic [7:0] addr, input logic [31:0] wdata,
                         input bit early_drop, input int mfc_cycles,
                         input logic [31:0] lit);
    int strobe_at;
    int mfc_at;
    int mfc_len;
    strobe_at = -1;
    mfc_at = -1;
    mfc_len = 0;
    @(negedge Clk);
    MFA = 1'b1;
    READ_WRITE = rw;
    WORD_BYTE = wb;
    MEMADD = addr;
    MEMDAT_IN = wdata;
    for (int j = 1; j <= 20; j++) begin
      @(negedge Clk);
      if (j == 1) begin
        MEMADD = ~addr;
        READ_WRITE = ~rw;
        WORD_BYTE = ~wb;
        if (early_drop) MFA = 1'b0;
      end
      if ((MEMLOAD || MEMSTORE) && strobe_at < 0) begin
        strobe_at = j;
        if (rw) check({tag, "_data"}, MEMDAT_OUT, lit);
        else check({tag, "_store"}, {31'h0, MEMSTORE}, 32'h1);
      end
      if (MFC) begin
        if (mfc_at < 0) mfc_at = j;
        mfc_len++;
        if (mfc_len >= mfc_cycles) MFA = 1'b0;
      end else if (mfc_at >= 0) begin
        break;
      end
    end
    MFA = 1'b0;
    check({tag, "_strobe_cycle"}, strobe_at, LAT + 1);
    check({tag, "_mfc_cycle"}, mfc_at, LAT + 2);
    check({tag, "_mfc_len"}, mfc_len, mfc_cycles);
    $display("txn %s rw=%0d wb=%0d addr=0x%02h strobe@%0d mfc@%0d len=%0d dout=0x%08h",
             tag, rw, wb, addr, strobe_at, mfc_at, mfc_len, MEMDAT_OUT);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    Reset = 1'b0;
    MFA = 1'b0;
    READ_WRITE = 1'b1;
    WORD_BYTE = 1'b1;
    MEMADD = 8'h0;
    MEMDAT_IN = 32'h0;

    // Reset for two cycles, then idle with MFA low.
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("rst_MFC", MFC, 0);
    check("rst_MEMLOAD", MEMLOAD, 0);
    check("rst_MEMSTORE", MEMSTORE, 0);
    check("rst_MEMDAT_OUT", MEMDAT_OUT, 32'h0);
    saw = 1'b0;
    repeat (4) begin
      @(negedge Clk);
      if (MFC || MEMLOAD || MEMSTORE) saw = 1'b1;
    end
    check("idle_no_strobe", saw, 0);
    $display("txn reset_idle saw_strobe=%0d", saw);

    // Word write then word read; MFC held three cycles.
    request("wr_word_10", 1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 3, 32'h0);
    request("rd_word_10", 1'b1, 1'b1, 8'h10, 32'h0, 1'b0, 2, 32'hDEADBEEF);

    // Byte write to lane 3 only, then word and byte reads.
    request("wr_byte_13", 1'b0, 1'b0, 8'h13, 32'hFFFFFFA5, 1'b0, 1, 32'h0);
    request("rd_word_10b", 1'b1, 1'b1, 8'h10, 32'h0, 1'b0, 1, 32'hA5ADBEEF);
    request("rd_byte_11", 1'b1, 1'b0, 8'h11, 32'h0, 1'b0, 1, 32'h000000BE);
    request("rd_byte_13", 1'b1, 1'b0, 8'h13, 32'h0, 1'b0, 1, 32'h000000A5);

    // Misaligned word read returns the aligned word.
    request("rd_word_12", 1'b1, 1'b1, 8'h12, 32'h0, 1'b0, 1, 32'hA5ADBEEF);

    // Reset in the second WAIT cycle aborts a write.
    request("wr_word_20", 1'b0, 1'b1, 8'h20, 32'hCAFEF00D, 1'b0, 1, 32'h0);
    @(negedge Clk);
    MFA = 1'b1;
    READ_WRITE = 1'b0;
    WORD_BYTE = 1'b1;
    MEMADD = 8'h20;
    MEMDAT_IN = 32'h12345678;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    MFA = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      @(negedge Clk);
      if (MFC || MEMSTORE) saw = 1'b1;
    end
    check("abort_no_strobe", saw, 0);
    $display("txn abort_write addr=0x20 saw_strobe=%0d", saw);
    request("rd_word_20", 1'b1, 1'b1, 8'h20, 32'h0, 1'b0, 1, 32'hCAFEF00D);

    // Single-cycle MFA, then a back-to-back request after one low cycle.
    request("rd_pulse_10", 1'b1, 1'b1, 8'h10, 32'h0, 1'b1, 1, 32'hA5ADBEEF);
    request("rd_b2b_11", 1'b1, 1'b0, 8'h11, 32'h0, 1'b0, 1, 32'h000000BE);

    // Early drop on a byte write still commits it.
    request("wr_pulse_22", 1'b0, 1'b0, 8'h22, 32'h0000003C, 1'b1, 1, 32'h0);
    request("rd_word_20b", 1'b1, 1'b1, 8'h20, 32'h0, 1'b0, 1, 32'hCA3CF00D);

    repeat (3) @(negedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
